cache_result_logger: RTL



---
 rtl/cache_result_logger.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cache_result_logger.sv
// Captures dcache/icache read results into a FIFO and drains them one line at a time to the
// hex UART. Optional overflow report line enabled by CACHE_LOGGER_DROPREPORT_EN.
module cache_result_logger #(
    parameter int unsigned DATABITS  = 32,
    parameter int unsigned DEPTHBITS = 4,
    parameter logic [7:0]  DPREFIX   = 8'h44,
    parameter logic [7:0]  IPREFIX   = 8'h49
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATABITS-1:0]  dcache_out,
    input  logic                 dcache_out_valid,
    input  logic [DATABITS-1:0]  icache_out,
    input  logic                 icache_out_valid,
    output logic [7:0]           uart_prefix,
    output logic [31:0]          uart_value,
    output logic                 uart_start,
    input  logic                 uart_ready,
    output logic [DEPTHBITS:0]   fifo_level,
    output logic [15:0]          drop_count,
    output logic                 busy
);

    localparam int unsigned DEPTH = 1 << DEPTHBITS;
    localparam logic [DEPTHBITS:0] FULL_DIFF = {1'b1, {DEPTHBITS{1'b0}}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEND  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic              d_valid_q, i_valid_q;
    logic              d_evt, i_evt;
    logic [31:0]       d_ext, i_ext;

    logic              hold_valid_q, hold_valid_d;
    logic [31:0]       hold_value_q, hold_value_d;

    logic [39:0]       mem [DEPTH];
    logic [DEPTHBITS:0] wr_ptr_q, rd_ptr_q;
    logic              fifo_empty, fifo_full;
    logic              push, pop, write_ok, drop, report;
    logic [39:0]       push_entry, head;

    logic [1:0]        state_q, state_d;
    logic              start_q, start_d;
    logic [7:0]        prefix_q, prefix_d;
    logic [31:0]       value_q, value_d;
    logic [15:0]       drop_q, drop_d;

    assign d_evt = dcache_out_valid & ~d_valid_q;
    assign i_evt = icache_out_valid & ~i_valid_q;
    assign d_ext = 32'(dcache_out);
    assign i_ext = 32'(icache_out);

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == FULL_DIFF);
    assign head       = mem[rd_ptr_q[DEPTHBITS-1:0]];

    // dcache always wins the write port; a held icache result beats a new icache event.
    always_comb begin
        push         = 1'b0;
        push_entry   = '0;
        hold_valid_d = hold_valid_q;
        hold_value_d = hold_value_q;
        if (d_evt) begin
            push       = 1'b1;
            push_entry = {DPREFIX, d_ext};
            if (i_evt && !hold_valid_q) begin
                hold_valid_d = 1'b1;
                hold_value_d = i_ext;
            end
        end else if (hold_valid_q) begin
            push         = 1'b1;
            push_entry   = {IPREFIX, hold_value_q};
            hold_valid_d = 1'b0;
        end else if (i_evt) begin
            push       = 1'b1;
            push_entry = {IPREFIX, i_ext};
        end
    end

    assign pop      = (state_q == IDLE) && uart_ready && !fifo_empty;
    assign write_ok = push && (!fifo_full || pop);
    assign drop     = push && fifo_full && !pop;

`ifdef CACHE_LOGGER_DROPREPORT_EN
    assign report = (state_q == IDLE) && uart_ready && fifo_empty && !hold_valid_q &&
                    (drop_q != 16'd0);
`else
    assign report = 1'b0;
`endif

    always_comb begin
        drop_d = drop_q;
        if (drop && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
        if (report) begin
            drop_d = {15'd0, drop};
        end
    end

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        prefix_d = prefix_q;
        value_d  = value_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    prefix_d = head[39:32];
                    value_d  = head[31:0];
                    start_d  = 1'b1;
                    state_d  = SEND;
                end else if (report) begin
                    prefix_d = 8'h58;
                    value_d  = {16'h0, drop_q};
                    start_d  = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (!uart_ready) begin
                    start_d = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (uart_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_valid_q    <= 1'b0;
            i_valid_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_value_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= IDLE;
            start_q      <= 1'b0;
            prefix_q     <= '0;
            value_q      <= '0;
            drop_q       <= '0;
        end else begin
            d_valid_q    <= dcache_out_valid;
            i_valid_q    <= icache_out_valid;
            hold_valid_q <= hold_valid_d;
            hold_value_q <= hold_value_d;
            if (write_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            state_q      <= state_d;
            start_q      <= start_d;
            prefix_q     <= prefix_d;
            value_q      <= value_d;
            drop_q       <= drop_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (write_ok) begin
            mem[wr_ptr_q[DEPTHBITS-1:0]] <= push_entry;
        end
    end

    assign uart_prefix = prefix_q;
    assign uart_value  = value_q;
    assign uart_start  = start_q;
    assign fifo_level  = wr_ptr_q - rd_ptr_q;
    assign drop_count  = drop_q;
    assign busy        = (fifo_level != '0) || (state_q != IDLE) || hold_valid_q;

endmodule
